// File: rtl/picomips_pkg.sv
// Shared constants, loader state encoding and byte-count helper for the
// picomips program memory and its loader.
package picomips_pkg;

   localparam int I_SIZE_DEF = 24;
   localparam int P_SIZE_DEF = 5;

   typedef enum logic [2:0] {IDLE, RECV, WRITE, CHECK, DONE} state_t;

   // Bytes needed to carry one instruction word.
   function automatic int nbytes(input int isize);
      return (isize + 7) / 8;
   endfunction

endpackage

// File: rtl/program_loader_byte_assembler.sv
// Big-endian byte-to-word shift register with a byte index; word is the
// assembled value including the byte being shifted in this cycle.
module byte_assembler
   import picomips_pkg::*;
#(
   parameter int I_SIZE = I_SIZE_DEF
) (
   input  logic              clk,
   input  logic              nReset,
   input  logic              clr,
   input  logic              shift,
   input  logic [7:0]        din,
   output logic [I_SIZE-1:0] word,
   output logic              complete
);

   localparam int NB = nbytes(I_SIZE);
   localparam int W  = NB * 8;
   localparam int IW = (NB > 1) ? $clog2(NB) : 1;

   logic [IW-1:0] idx;

   assign complete = shift && (idx == IW'(NB - 1));

   generate
      if (NB == 1) begin : g_single
         assign word = din[I_SIZE-1:0];
      end else begin : g_multi
         // Only the earlier bytes need storage; the last byte comes straight from din.
         logic [W-9:0] sr;
         logic [W-1:0] sr_next;
         assign sr_next = {sr, din};
         assign word    = sr_next[I_SIZE-1:0];
         always_ff @(posedge clk or negedge nReset) begin
            if (!nReset)    sr <= '0;
            else if (shift) sr <= sr_next[W-9:0];
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset)       idx <= '0;
      else if (clr)      idx <= '0;
      else if (complete) idx <= '0;
      else if (shift)    idx <= IW'(idx + 1'b1);
   end

endmodule

// File: rtl/program_loader.sv
// Streams bytes into 2^P_SIZE program words and writes them to program memory.
// Define LOADER_CHECKSUM_EN to require a trailing checksum byte.
module program_loader
   import picomips_pkg::*;
#(
   parameter int I_SIZE = I_SIZE_DEF,
   parameter int P_SIZE = P_SIZE_DEF
) (
   input  logic              clk,
   input  logic              nReset,
   input  logic              startIn,
   input  logic [7:0]        byteIn,
   input  logic              byteValidIn,
   output logic              byteReadyOut,
   output logic              memWriteEnableOut,
   output logic [P_SIZE-1:0] memAddressOut,
   output logic [I_SIZE-1:0] memDataOut,
   output logic              busyOut,
   output logic              doneOut,
   output logic              errorOut
);

   localparam logic [P_SIZE-1:0] LAST = '1;

   state_t            state;
   logic [P_SIZE-1:0] addr;
   logic              xfer, shift, clr, complete;
   logic [I_SIZE-1:0] word;

   assign xfer  = byteValidIn && byteReadyOut;
   assign shift = xfer && (state == RECV);
   assign clr   = startIn && ((state == IDLE) || (state == DONE));

   byte_assembler #(.I_SIZE(I_SIZE)) u_asm (
      .clk      (clk),
      .nReset   (nReset),
      .clr      (clr),
      .shift    (shift),
      .din      (byteIn),
      .word     (word),
      .complete (complete)
   );

`ifdef LOADER_CHECKSUM_EN
   logic [7:0] sum;
`else
   assign errorOut = 1'b0;
`endif

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         state             <= IDLE;
         addr              <= '0;
         byteReadyOut      <= 1'b0;
         memWriteEnableOut <= 1'b0;
         memAddressOut     <= '0;
         memDataOut        <= '0;
         busyOut           <= 1'b0;
         doneOut           <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         sum               <= '0;
         errorOut          <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE, DONE: begin
               if (startIn) begin
                  state        <= RECV;
                  addr         <= '0;
                  byteReadyOut <= 1'b1;
                  busyOut      <= 1'b1;
                  doneOut      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                  sum          <= '0;
                  errorOut     <= 1'b0;
`endif
               end
            end
            RECV: begin
               if (shift) begin
`ifdef LOADER_CHECKSUM_EN
                  sum <= 8'(sum + byteIn);
`endif
                  if (complete) begin
                     state             <= WRITE;
                     byteReadyOut      <= 1'b0;
                     memWriteEnableOut <= 1'b1;
                     memAddressOut     <= addr;
                     memDataOut        <= word;
                  end
               end
            end
            WRITE: begin
               memWriteEnableOut <= 1'b0;
               if (addr == LAST) begin
`ifdef LOADER_CHECKSUM_EN
                  state        <= CHECK;
                  byteReadyOut <= 1'b1;
`else
                  state        <= DONE;
                  busyOut      <= 1'b0;
                  doneOut      <= 1'b1;
`endif
               end else begin
                  addr         <= addr + 1'b1;
                  state        <= RECV;
                  byteReadyOut <= 1'b1;
               end
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
               // Data bytes plus checksum must sum to zero modulo 256.
               if (xfer) begin
                  state        <= DONE;
                  byteReadyOut <= 1'b0;
                  busyOut      <= 1'b0;
                  if (8'(sum + byteIn) == 8'd0) doneOut  <= 1'b1;
                  else                          errorOut <= 1'b1;
               end
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected writes are queued by the
// stimulus and checked by a monitor on every write strobe.
module tb_program_loader;

   logic        clk = 1'b0;
   logic        nReset = 1'b0;
   logic        startIn = 1'b0;
   logic [7:0]  byteIn = 8'h00;
   logic        byteValidIn = 1'b0;
   logic        byteReadyOut, memWriteEnableOut, busyOut, doneOut, errorOut;
   logic [4:0]  memAddressOut;
   logic [23:0] memDataOut;

   int vectors = 0;
   int miscompares = 0;
   logic [28:0] sb[$];
   logic [7:0]  bq[$];

   always #5 clk = ~clk;

   program_loader dut (
      .clk               (clk),
      .nReset            (nReset),
      .startIn           (startIn),
      .byteIn            (byteIn),
      .byteValidIn       (byteValidIn),
      .byteReadyOut      (byteReadyOut),
      .memWriteEnableOut (memWriteEnableOut),
      .memAddressOut     (memAddressOut),
      .memDataOut        (memDataOut),
      .busyOut           (busyOut),
      .doneOut           (doneOut),
      .errorOut          (errorOut)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Monitor: every write strobe must match the head of the scoreboard.
   always @(negedge clk) begin
      if (nReset && memWriteEnableOut) begin
         if (sb.size() == 0) begin
            chk("unexpected_write", {3'b0, memAddressOut, memDataOut}, 32'hFFFFFFFF);
         end else begin
            chk("write_addr_data", {3'b0, memAddressOut, memDataOut}, {3'b0, sb.pop_front()});
            chk("ready_low_in_write", {31'b0, byteReadyOut}, 32'd0);
            chk("busy_in_write", {31'b0, busyOut}, 32'd1);
         end
      end
   end

   task automatic fill_bytes();
      bq.delete();
      for (int k = 0; k < 32; k++) begin
         bq.push_back(8'(k));
         bq.push_back(8'hA5);
         bq.push_back(~8'(k));
      end
   endtask

   task automatic push_words(input int n);
      for (int k = 0; k < n; k++) sb.push_back({5'(k), 8'(k), 8'hA5, ~8'(k)});
   endtask

   task automatic pulse_start();
      @(negedge clk) startIn = 1'b1;
      @(negedge clk) startIn = 1'b0;
   endtask

   // Sends the first n bytes of bq; optionally pulses startIn while byte start_at is offered.
   task automatic send_bytes(input int n, input bit gaps, input int start_at);
      int idx = 0;
      int guard = 0;
      bit pulsed = 1'b0;
      while (idx < n && guard < 4000) begin
         @(negedge clk);
         byteValidIn = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         byteIn = bq[idx];
         if (!pulsed && idx == start_at) begin
            startIn = 1'b1;
            pulsed = 1'b1;
         end else begin
            startIn = 1'b0;
         end
         if (byteValidIn && byteReadyOut) idx++;
         guard++;
      end
      @(negedge clk);
      byteValidIn = 1'b0;
      startIn = 1'b0;
      if (idx < n) chk("send_timeout", idx, n);
   endtask

   task automatic do_load(input bit gaps, input int start_at, input bit bad_cs);
      int c = 0;
      fill_bytes();
      push_words(32);
      pulse_start();
      chk("busy_after_start", {31'b0, busyOut}, 32'd1);
      send_bytes(96, gaps, start_at);
`ifdef LOADER_CHECKSUM_EN
      // 32 words of k + A5 + ~k sum to 8'h80, so 8'h80 balances it.
      bq.delete();
      bq.push_back(bad_cs ? 8'h81 : 8'h80);
      send_bytes(1, gaps, -1);
`endif
      while (!doneOut && !errorOut && c < 50) begin
         @(negedge clk);
         c++;
      end
      chk("done_flags", {29'b0, busyOut, doneOut, errorOut}, {29'b0, 1'b0, !bad_cs, bad_cs});
      chk("sb_drained", sb.size(), 0);
   endtask

   initial begin
      // Reset and idle behaviour.
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", {byteReadyOut, memWriteEnableOut, memAddressOut, busyOut, doneOut, errorOut},
          32'd0);
      chk("reset_data", {8'b0, memDataOut}, 32'd0);
      nReset = 1'b1;
      byteValidIn = 1'b1;
      byteIn = 8'h3C;
      repeat (4) begin
         @(negedge clk);
         chk("idle_ready", {30'b0, byteReadyOut, busyOut}, 32'd0);
      end
      byteValidIn = 1'b0;

      // Continuous full load, then one with random gaps.
      do_load(1'b0, -1, 1'b0);
      do_load(1'b1, -1, 1'b0);

      // Reset after 40 bytes: words 0..12 only.
      fill_bytes();
      push_words(13);
      pulse_start();
      send_bytes(40, 1'b0, -1);
      nReset = 1'b0;
      #1;
      chk("midload_reset_outputs",
          {byteReadyOut, memWriteEnableOut, memAddressOut, busyOut, doneOut, errorOut}, 32'd0);
      chk("midload_words", sb.size(), 0);
      sb.delete();
      repeat (2) @(negedge clk);
      nReset = 1'b1;
      repeat (3) @(negedge clk);
      do_load(1'b0, -1, 1'b0);

      // Start pulse while busy is ignored.
      do_load(1'b1, 10, 1'b0);

`ifdef LOADER_CHECKSUM_EN
      do_load(1'b0, -1, 1'b1);
      do_load(1'b0, -1, 1'b0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Write-side counterpart to the asynchronous-read program memory.
- Accepts a byte stream over a valid/ready handshake and assembles it into I_SIZE-bit instructions.
- Writes each instruction into a writable program memory on one write port.
- Holds the CPU in reset (busy) while loading; used for in-system program download in place of a file-initialised image.

Parameters:
- I_SIZE, 24, instruction width in bits.
- P_SIZE, 5, address width; the block loads exactly 2^P_SIZE words per load.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- nReset  input  1  asynchronous active-low reset.
- startIn  input  1  single-cycle pulse that begins a load.
- byteIn  input  8  stream data byte.
- byteValidIn  input  1  byteIn holds a valid byte.
- byteReadyOut  output  1  loader can accept a byte this cycle.
- memWriteEnableOut  output  1  write strobe to program memory.
- memAddressOut  output  P_SIZE  write address.
- memDataOut  output  I_SIZE  write data.
- busyOut  output  1  load in progress; used to hold the CPU in reset.
- doneOut  output  1  load completed successfully.
- errorOut  output  1  load failed (checksum; only meaningful with option).

Behaviour:
- Reset (nReset low, asynchronous) forces state IDLE.
  - All outputs 0.
  - Address counter 0, byte index 0, assembly register 0.
- Derived constant NBYTES = ceil(I_SIZE/8), which is 3 at default.
- Byte transfer occurs only on a cycle where byteValidIn && byteReadyOut.
- Byte ordering is big-endian: the first byte of a word supplies the MSBs. When I_SIZE is not a multiple of 8, excess high bits of the first byte are discarded.
- IDLE:
  - byteReadyOut=0, busyOut=0.
  - startIn -> RECV; address and byte index cleared, doneOut/errorOut cleared.
- RECV:
  - byteReadyOut=1, busyOut=1.
  - Each transfer shifts the byte into the assembly register and increments the byte index.
  - On the transfer with index NBYTES-1 -> WRITE next cycle.
  - Bytes offered while byteReadyOut=0 are not consumed.
- WRITE (exactly one cycle):
  - memWriteEnableOut=1, memAddressOut = current address, memDataOut = assembled word (registered outputs).
  - byteReadyOut=0.
  - If address == 2^P_SIZE-1 -> DONE (or CHECK when the option is enabled); otherwise address+1, byte index 0, -> RECV.
- DONE:
  - doneOut=1, busyOut=0, byteReadyOut=0.
  - State holds until startIn, which restarts as from IDLE and clears doneOut/errorOut the next cycle.
- Latency: the write strobe asserts 1 cycle after the last byte of a word is accepted. Minimum load time is 2^P_SIZE*(NBYTES+1) cycles.
- Address wrap never occurs: the load terminates at the last address.
- startIn while busyOut=1 is ignored.
- Reset mid-load aborts immediately. Words already written remain in memory; no rollback.
- memAddressOut/memDataOut hold their last values when memWriteEnableOut=0.

Optional Feature:
- Macro LOADER_CHECKSUM_EN.
- Enabled:
  - The loader maintains an 8-bit running sum of all data bytes.
  - After the final WRITE it enters CHECK with byteReadyOut=1 and accepts one extra checksum byte.
  - If (sum + checksum) mod 256 == 0 -> DONE with doneOut=1; else -> DONE with doneOut=0, errorOut=1.
  - busyOut stays 1 during CHECK.
- Disabled: no CHECK state and no sum register; errorOut is tied 0.

Decomposition:
- Shared package picomips_pkg:
  - State enum (IDLE, RECV, WRITE, CHECK, DONE).
  - NBYTES computation function.
  - Default I_SIZE/P_SIZE constants shared with program memory.
- One natural sub-module, byte_assembler: a shift register plus byte index counter with a word-complete flag. All other logic is a single FSM.

Test Plan:
- Reset then idle: nReset low for 2 cycles -> all outputs 0; byteValidIn=1 with no start -> byteReadyOut stays 0, no write.
- Full load at defaults: startIn, then 96 bytes with valid continuously high, word k = {k, 8'hA5, ~k} -> 32 writes at addresses 0..31; write 5 data = 24'h05A5FA; doneOut=1 after the final write; busyOut 1 throughout the load.
- Backpressure/gaps: byteValidIn toggled randomly -> identical memory contents; memWriteEnableOut is exactly one cycle per word; no byte is accepted during WRITE.
- Reset mid-load: nReset asserted after 40 bytes -> outputs 0 immediately, words 0..12 written, no further writes; a new startIn reloads from address 0.
- Start ignored while busy: startIn pulsed at byte 10 -> no restart, address sequence continues unbroken.
- LOADER_CHECKSUM_EN: full load followed by a correct checksum byte -> doneOut=1, errorOut=0; the same load with checksum+1 -> doneOut=0, errorOut=1.
